// File: rtl/mem_read_b_pkg.sv
// Shared definitions for the B-matrix bank read and write stages.
package mem_read_b_pkg;

  // Sequencer states for the B read stage.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  // B-bank geometry shared with the B write stage.
  localparam int B_ADDR_W       = 12;
  localparam int B_MATRIXSIZE_W = 16;

endpackage

// File: rtl/mem_read_b_if.sv
// Job request, bank read strobe and status signals of the B read stage.
interface mem_read_b_if
  import mem_read_b_pkg::*;
#(
  parameter int MATRIXSIZE_W = B_MATRIXSIZE_W,
  parameter int ADDR_W       = B_ADDR_W
) ();

  logic                    start;
  logic [MATRIXSIZE_W-1:0] M2;
  logic [MATRIXSIZE_W-1:0] M3dN2;
  logic [MATRIXSIZE_W-1:0] M1dN1;
  logic                    ready_B;
  logic [ADDR_W-1:0]       rd_addr_B;
  logic                    rd_en_B;
  logic                    valid_out_B;
  logic                    last_out_B;
  logic                    busy;
  logic                    done;

  // Job controller / downstream side.
  modport master (
    output start, M2, M3dN2, M1dN1, ready_B,
    input  rd_addr_B, rd_en_B, valid_out_B, last_out_B, busy, done
  );

  // Read sequencer side.
  modport slave (
    input  start, M2, M3dN2, M1dN1, ready_B,
    output rd_addr_B, rd_en_B, valid_out_B, last_out_B, busy, done
  );

endinterface

// File: rtl/mem_read_b_pipe_delay.sv
// Fixed-depth shift register that aligns strobes with bank read latency.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dly_p [DEPTH];

  // Shift one stage per clock; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) dly_p[i] <= '0;
    end else begin
      dly_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) dly_p[i] <= dly_p[i-1];
    end
  end

  assign dout = dly_p[DEPTH-1];

endmodule

// File: rtl/mem_read_b.sv
// B-matrix bank read sequencer: walks pass / column block / row and issues
// one shared address to all N2 banks per accepted read.
module mem_read_b
  import mem_read_b_pkg::*;
#(
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = B_MATRIXSIZE_W,
  parameter int ADDR_W       = B_ADDR_W,
  parameter int RD_LAT       = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_read_b_if.slave  bus
);

  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  if (RD_LAT < 1 || N2 < 1) begin : g_bad_param
    $error("mem_read_b: RD_LAT and N2 must be at least 1");
  end

  rd_state_e               state_q;
  logic [MATRIXSIZE_W-1:0] m2_q, m3_q, m1_q;
  logic [MATRIXSIZE_W-1:0] r_q, p_q, pass_q;
  logic [ADDR_W-1:0]       base_q, addr_q;
  logic [DW-1:0]           drain_q;
  logic                    busy_q, done_q;

  logic [MATRIXSIZE_W-1:0] m2_lim, m3_lim, m1_lim;
  logic                    r_end, p_end, pass_end;
  logic                    issue, issue_last, size_zero;
  logic                    vld_pl, last_pl;

  assign m2_lim     = m2_q - MATRIXSIZE_W'(1);
  assign m3_lim     = m3_q - MATRIXSIZE_W'(1);
  assign m1_lim     = m1_q - MATRIXSIZE_W'(1);
  assign r_end      = (r_q == m2_lim);
  assign p_end      = (p_q == m3_lim);
  assign pass_end   = (pass_q == m1_lim);
  assign issue      = (state_q == READ) && bus.ready_B;
  assign issue_last = issue && r_end && p_end && pass_end;
  assign size_zero  = (bus.M2 == '0) || (bus.M3dN2 == '0) || (bus.M1dN1 == '0);

  // Sequencer: job acceptance, address/counter walk, drain and completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      m2_q    <= '0;
      m3_q    <= '0;
      m1_q    <= '0;
      r_q     <= '0;
      p_q     <= '0;
      pass_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            m2_q    <= bus.M2;
            m3_q    <= bus.M3dN2;
            m1_q    <= bus.M1dN1;
            r_q     <= '0;
            p_q     <= '0;
            pass_q  <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            if (size_zero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (issue) begin
            if (!r_end) begin
              r_q    <= r_q + MATRIXSIZE_W'(1);
              addr_q <= addr_q + ADDR_W'(1);
            end else begin
              r_q <= '0;
              if (!p_end) begin
                // Next column block starts M2 rows further on; addition only.
                p_q    <= p_q + MATRIXSIZE_W'(1);
                base_q <= base_q + ADDR_W'(m2_q);
                addr_q <= base_q + ADDR_W'(m2_q);
              end else begin
                p_q    <= '0;
                base_q <= '0;
                addr_q <= '0;
                if (!pass_end) begin
                  pass_q <= pass_q + MATRIXSIZE_W'(1);
                end else begin
                  pass_q  <= '0;
                  drain_q <= '0;
                  state_q <= DRAIN;
                end
              end
            end
          end
        end
        DRAIN: begin
          // Wait for the last read's data to leave the banks.
          if (drain_q == DW'(RD_LAT - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  pipe_delay #(
    .WIDTH (2),
    .DEPTH (RD_LAT)
  ) u_pipe_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({issue, issue_last}),
    .dout ({vld_pl, last_pl})
  );

  assign bus.rd_en_B     = issue;
  assign bus.rd_addr_B   = addr_q;
  assign bus.valid_out_B = vld_pl;
  assign bus.last_out_B  = last_pl;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
